// File: rtl/simd_pkg.sv
// Shared SIMD lane definitions: divider state encoding, saturation limits and counter sizing.
// Saturation helpers support operand widths up to SAT_CALC_W bits.
package simd_pkg;

  localparam int unsigned DIV_BIT_WIDTH = 32;
  localparam int unsigned SAT_CALC_W    = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Largest positive two's-complement value of width w, zero-extended
  function automatic logic [SAT_CALC_W-1:0] sat_max(input int unsigned w);
    return (SAT_CALC_W'(1) << (w - 1)) - SAT_CALC_W'(1);
  endfunction

  // Most negative two's-complement value of width w, zero-extended
  function automatic logic [SAT_CALC_W-1:0] sat_min(input int unsigned w);
    return SAT_CALC_W'(1) << (w - 1);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/simd_div_step.sv
// One restoring-division step: shift in the next dividend bit and trial-subtract the divisor.
module simd_div_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_c_o,
  output logic         q_c_o
);

  logic [W:0] shifted_c;
  logic [W:0] diff_c;

  // Partial remainder stays below the divisor, so W+1 bits hold the sign of the trial
  always_comb begin
    shifted_c = {rem_i, bit_i};
    diff_c    = shifted_c - {1'b0, dvs_i};
    q_c_o     = ~diff_c[W];
    rem_c_o   = q_c_o ? diff_c[W-1:0] : shifted_c[W-1:0];
  end

endmodule

// File: rtl/simd_divider_unit.sv
// Iterative signed divider (one quotient bit per cycle) with saturated quotient and valid/ready handshakes.
// Define SIMD_DIV_REM_EN to add the signed remainder output rem_out.
module simd_divider_unit
  import simd_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = DIV_BIT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] dividend,
  input  logic [BIT_WIDTH-1:0] divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] quotient,
`ifdef SIMD_DIV_REM_EN
  output logic [BIT_WIDTH-1:0] rem_out,
`endif
  output logic                 div_by_zero
);

  localparam int unsigned W     = BIT_WIDTH;
  localparam int unsigned CNT_W = cnt_width(BIT_WIDTH);
  localparam logic [W-1:0] SAT_MAX = W'(sat_max(W));
  localparam logic [W-1:0] SAT_MIN = W'(sat_min(W));

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     rem_q, rem_d;
  logic [W-1:0]     dvd_q, dvd_d;
  logic [W-1:0]     dvs_q, dvs_d;
  logic             qsign_q, qsign_d;
  logic             special_q, special_d;
  logic [W-1:0]     quot_q, quot_d;
  logic             dbz_q, dbz_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
`ifdef SIMD_DIV_REM_EN
  logic             rsign_q, rsign_d;
  logic [W-1:0]     rem_out_q, rem_out_d;
`endif

  logic [W-1:0] step_rem_c;
  logic         step_q_c;

  simd_div_step #(.W(W)) u_step (
    .rem_i   (rem_q),
    .bit_i   (dvd_q[W-1]),
    .dvs_i   (dvs_q),
    .rem_c_o (step_rem_c),
    .q_c_o   (step_q_c)
  );

  // Next-state and datapath; special results settle through FIX so every result has one exit path
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    qsign_d     = qsign_q;
    special_d   = special_q;
    quot_d      = quot_q;
    dbz_d       = dbz_q;
    out_valid_d = out_valid_q;
`ifdef SIMD_DIV_REM_EN
    rsign_d     = rsign_q;
    rem_out_d   = rem_out_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d     = dividend[W-1] ? (W'(0) - dividend) : dividend;
          dvs_d     = divisor[W-1]  ? (W'(0) - divisor)  : divisor;
          qsign_d   = dividend[W-1] ^ divisor[W-1];
`ifdef SIMD_DIV_REM_EN
          rsign_d   = dividend[W-1];
`endif
          dbz_d     = (divisor == '0);
          special_d = 1'b0;
          rem_d     = '0;
          cnt_d     = CNT_W'(W);
          if (divisor == '0) begin
            special_d = 1'b1;
            dvd_d     = dividend[W-1] ? SAT_MIN : SAT_MAX;
            rem_d     = dividend;
            state_d   = FIX;
          end else if ((dividend == SAT_MIN) && (divisor == '1)) begin
            special_d = 1'b1;
            dvd_d     = SAT_MAX;
            state_d   = FIX;
          end else begin
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        rem_d = step_rem_c;
        dvd_d = {dvd_q[W-2:0], step_q_c};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        quot_d      = (special_q || !qsign_q) ? dvd_q : (W'(0) - dvd_q);
`ifdef SIMD_DIV_REM_EN
        rem_out_d   = (special_q || !rsign_q) ? rem_q : (W'(0) - rem_q);
`endif
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      qsign_q     <= 1'b0;
      special_q   <= 1'b0;
      quot_q      <= '0;
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef SIMD_DIV_REM_EN
      rsign_q     <= 1'b0;
      rem_out_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      qsign_q     <= qsign_d;
      special_q   <= special_d;
      quot_q      <= quot_d;
      dbz_q       <= dbz_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef SIMD_DIV_REM_EN
      rsign_q     <= rsign_d;
      rem_out_q   <= rem_out_d;
`endif
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quot_q;
  assign div_by_zero = dbz_q;
`ifdef SIMD_DIV_REM_EN
  assign rem_out     = rem_out_q;
`endif

endmodule

// File: tb/tb_simd_divider_unit.sv
// Randomized self-checking bench for simd_divider_unit against a plain-arithmetic division model.
module tb_simd_divider_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic        div_by_zero;
`ifdef SIMD_DIV_REM_EN
  logic [31:0] rem_out;
`endif

  int total = 0;
  int bad   = 0;

  simd_divider_unit #(.BIT_WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
`ifdef SIMD_DIV_REM_EN
    .rem_out     (rem_out),
`endif
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: truncating signed division with saturation of the two overflow cases
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic z, output int lat);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    z = (b == 32'h0);
    if (z) begin
      q = (sa < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      r = a;
      lat = 1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h7FFF_FFFF;
      r = 32'h0;
      lat = 1;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      lat = 33;
    end
  endfunction

  function automatic logic [31:0] rnd_operand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'($urandom_range(0, 400)) - 32'd200;
      1: v = 32'h0;
      2: v = 32'h8000_0000;
      3: v = ($urandom_range(0, 1) == 1) ? 32'h1 : 32'hFFFF_FFFF;
      4: v = 32'h7FFF_FFFF - 32'($urandom_range(0, 3));
      default: v = $urandom();
    endcase
    return v;
  endfunction

  // Issue one pair with out_ready high; report latency, captured result and handshake observations
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] q, output logic [31:0] r,
                       output logic z, output logic rdy_low, output logic z_at_accept);
    int guard = 0;
    out_ready = 1'b1;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid    = 1'b0;
    z_at_accept = div_by_zero;
    lat = 0;
    rdy_low = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_low = 1'b0;
      @(posedge clk); #1; lat++;
    end
    if (in_ready) rdy_low = 1'b0;
    if (lat >= 100) begin
      total++; bad++;
      $display("FAIL op_timeout: no out_valid within 100 cycles for %h / %h", a, b);
    end
    q = quotient;
    z = div_by_zero;
`ifdef SIMD_DIV_REM_EN
    r = rem_out;
`else
    r = 32'h0;
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dividend = 32'h0; divisor = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    total++; if (quotient !== 32'h0) begin bad++; $display("FAIL reset_quotient: got %h exp 0", quotient); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz: got %b exp 0", div_by_zero); end
`ifdef SIMD_DIV_REM_EN
    total++; if (rem_out !== 32'h0) begin bad++; $display("FAIL reset_rem: got %h exp 0", rem_out); end
`endif
  endtask

  // Directed table: sign combinations, zero divisor and the overflow boundary
  task automatic test_directed();
    logic [31:0] ta [10] = '{32'd100, -32'sd100, 32'd100, -32'sd100, 32'd5, -32'sd5,
                             32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0};
    logic [31:0] tb [10] = '{32'd7, 32'd7, -32'sd7, -32'sd7, 32'd0, 32'd0,
                             32'hFFFF_FFFF, 32'd1, 32'h8000_0000, 32'd0};
    for (int i = 0; i < 10; i++) begin
      int lat, elat;
      logic [31:0] q, r, eq, er;
      logic z, ez, rdy_low, za;
      ref_div(ta[i], tb[i], eq, er, ez, elat);
      do_op(ta[i], tb[i], lat, q, r, z, rdy_low, za);
      total++; if (q !== eq) begin bad++; $display("FAIL dir_quot[%0d]: got %h exp %h", i, q, eq); end
      total++; if (z !== ez) begin bad++; $display("FAIL dir_dbz[%0d]: got %b exp %b", i, z, ez); end
      total++; if (lat != elat) begin bad++; $display("FAIL dir_latency[%0d]: got %0d exp %0d", i, lat, elat); end
      total++; if (rdy_low !== 1'b1) begin bad++; $display("FAIL dir_in_ready_busy[%0d]: got high exp low", i); end
`ifdef SIMD_DIV_REM_EN
      total++; if (r !== er) begin bad++; $display("FAIL dir_rem[%0d]: got %h exp %h", i, r, er); end
`endif
    end
  endtask

  task automatic test_dbz_clear();
    int lat;
    logic [31:0] q, r;
    logic z, rdy_low, za;
    do_op(32'd5, 32'd0, lat, q, r, z, rdy_low, za);
    do_op(32'd100, 32'd7, lat, q, r, z, rdy_low, za);
    total++; if (za !== 1'b0) begin bad++; $display("FAIL dbz_clear_on_accept: got %b exp 0", za); end
    total++; if (z !== 1'b0) begin bad++; $display("FAIL dbz_after_normal: got %b exp 0", z); end
  endtask

  task automatic test_backpressure();
    int guard = 0;
    logic [31:0] eq, er;
    logic ez;
    int elat;
    ref_div(32'd50, -32'sd3, eq, er, ez, elat);
    out_ready = 1'b0;
    dividend = 32'd50; divisor = -32'sd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && guard < 100) begin @(posedge clk); #1; guard++; end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_timeout: out_valid got %b exp 1", out_valid); end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      dividend = $urandom();
      divisor  = $urandom();
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || quotient !== eq || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got v=%b q=%h rdy=%b exp v=1 q=%h rdy=0", i, out_valid, quotient, in_ready, eq);
      end
`ifdef SIMD_DIV_REM_EN
      total++; if (rem_out !== er) begin bad++; $display("FAIL bp_rem_hold[%0d]: got %h exp %h", i, rem_out, er); end
`endif
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain_valid: got %b exp 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_drain_in_ready: got %b exp 1", in_ready); end
    total++; if (quotient !== eq) begin bad++; $display("FAIL bp_no_new_accept: got %h exp %h", quotient, eq); end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] q, r;
    logic z, rdy_low, za;
    dividend = 32'd1000; divisor = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 32'h0 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL midreset_outputs: got rdy=%b v=%b q=%h z=%b exp 1 0 0 0", in_ready, out_valid, quotient, div_by_zero);
    end
`ifdef SIMD_DIV_REM_EN
    total++; if (rem_out !== 32'h0) begin bad++; $display("FAIL midreset_rem: got %h exp 0", rem_out); end
`endif
    do_op(32'd9, 32'd2, lat, q, r, z, rdy_low, za);
    total++; if (q !== 32'd4) begin bad++; $display("FAIL midreset_follow_quot: got %h exp 4", q); end
    total++; if (lat != 33) begin bad++; $display("FAIL midreset_follow_latency: got %0d exp 33", lat); end
`ifdef SIMD_DIV_REM_EN
    total++; if (r !== 32'd1) begin bad++; $display("FAIL midreset_follow_rem: got %h exp 1", r); end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int lat, elat;
      logic [31:0] a, b, q, r, eq, er;
      logic z, ez, rdy_low, za;
      a = rnd_operand();
      b = rnd_operand();
      ref_div(a, b, eq, er, ez, elat);
      do_op(a, b, lat, q, r, z, rdy_low, za);
      total++;
      if (q !== eq || z !== ez || lat != elat) begin
        bad++;
        $display("FAIL rand[%0d] %h/%h: got q=%h z=%b lat=%0d exp q=%h z=%b lat=%0d", i, a, b, q, z, lat, eq, ez, elat);
      end
`ifdef SIMD_DIV_REM_EN
      total++; if (r !== er) begin bad++; $display("FAIL rand_rem[%0d] %h/%h: got %h exp %h", i, a, b, r, er); end
`endif
    end
  endtask

  // Continuous in_valid with out_ready high: spacing between accepting edges
  task automatic test_back_to_back(input logic [31:0] a, input logic [31:0] b, input int exp_period);
    int acc[$];
    int guard = 0;
    out_ready = 1'b1;
    dividend = a; divisor = b; in_valid = 1'b1;
    for (int c = 0; c < 150 && acc.size() < 3; c++) begin
      if (in_ready) acc.push_back(c);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++;
    if (acc.size() < 3) begin
      bad++;
      $display("FAIL b2b_accepts: got %0d accepts exp 3", acc.size());
    end else if (acc[1] - acc[0] != exp_period || acc[2] - acc[1] != exp_period) begin
      bad++;
      $display("FAIL b2b_period: got %0d,%0d exp %0d", acc[1] - acc[0], acc[2] - acc[1], exp_period);
    end
    while (!(in_ready && !out_valid) && guard < 100) begin @(posedge clk); #1; guard++; end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_dbz_clear();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back(32'd77, -32'sd5, 35);
    test_back_to_back(32'd77, 32'd0, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
